vdmem_seq_ram: RTL and testbench
================================

// Module: vdmem_seq_ram
// PURPOSE
// - Next-generation data memory for the vector pipeline: scalar and LANES-wide vector load/store over a single-port word RAM.
// - Vector accesses are sequenced one lane per cycle; every request uses a valid/ready handshake and gets a one-cycle response.
// - Provides a synchronised memory-mapped switch region and a streaming dump port (valid/ready), so image readout is synthesisable hardware.
// PARAMETERS
// - W           32     data word width (bits)
// - LANES       6      words per vector access
// - DEPTH       30000  RAM words, addresses 0..DEPTH-1
// - AW          32     address width
// - IO_BASE     30000  first memory-mapped switch address; must be >= DEPTH
// - IO_BITS     9      number of switch inputs, one per word at IO_BASE+i
// - SYNC_STAGES 2      flop stages on sw_in and dump_start
// PORTS
// - clk         in   1        single clock, all logic on posedge
// - rst         in   1        synchronous, active-high reset
// - req_valid   in   1        request present
// - req_ready   out  1        request accepted when valid&ready
// - req_we      in   1        1=store, 0=load
// - req_vec     in   1        1=LANES-word access, 0=scalar (lane 0 only)
// - req_addr    in   AW       base word address
// - req_wdata   in   LANES*W  lane i at [i*W +: W]
// - rsp_valid   out  1        one-cycle pulse, exactly one per accepted request
// - rsp_rdata   out  LANES*W  load data (stores: 0); unused lanes 0
// - sw_in       in   IO_BITS  asynchronous switch inputs
// - dump_start  in   1        asynchronous; rising edge requests full dump
// - dump_valid  out  1        dump word valid
// - dump_ready  in   1        consumer accepts dump word
// - dump_addr   out  AW       address of dump_data
// - dump_data   out  W        RAM word
// - dump_done   out  1        one-cycle pulse after the last dump handshake
// BEHAVIOUR
// - Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, dump_valid=0, dump_addr=0, dump_data=0, dump_done=0; FSM->IDLE; pending dump cleared; sync flops=0. RAM contents are NOT cleared. req_ready=1 from the first cycle after rst deasserts.
// - FSM: IDLE, SEQ, RESP, DUMP. req_ready=1 only in IDLE with no dump pending.
// - IDLE: a pending dump edge has priority -> DUMP. Otherwise, on a handshake, latch addr/we/vec/wdata, clear lane counter -> SEQ.
// - SEQ: one lane per cycle, lane=0..N-1 (N=LANES if vec, else 1). Word address = base+lane (AW-bit, no wrap).
//   - Store: writes lane data.
//   - Load: uses the 1-cycle synchronous RAM read; lane data lands in rsp_rdata[lane].
//   - After lane N-1 -> RESP.
// - RESP: rsp_valid=1 for one cycle -> IDLE. rsp_rdata holds until the next response.
// - Latency: handshake at cycle t -> rsp_valid at t+N+1 (scalar t+2, vector t+7); next handshake possible at t+N+2.
// - Address decode per lane: addr<DEPTH selects RAM. IO_BASE<=addr<IO_BASE+IO_BITS reads zero-extended synced sw bit; writes there are ignored. Anything else: writes dropped, reads 0, no error.
// - Switches: SYNC_STAGES-flop synchronised; reads see the value 2 cycles after change (default).
// - Dump edge detect: on the synchronised dump_start, 0->1 sets pending. Edges while in SEQ/RESP/DUMP stay pending; one pending flag, so extra edges merge.
// - DUMP: addr 0..DEPTH-1 in order.
//   - dump_valid asserts once data is ready. dump_addr/dump_data stay stable while valid&!ready.
//   - Advance on valid&ready. Sustained throughput is 1 word/cycle when dump_ready=1.
//   - The cycle after the handshake at DEPTH-1: dump_valid=0, dump_done=1 for one cycle -> IDLE.
// - rst mid-SEQ: lanes written before the rst cycle persist; remaining lanes are not written; no rsp. rst mid-DUMP: stream aborts, no dump_done.
// TESTING
// - Scalar: store 0xDEADBEEF @5; load @5 -> rsp_valid 2 cycles after the load handshake, rsp_rdata[31:0]=0xDEADBEEF, upper lanes 0.
// - Vector: store lanes {1,2,3,4,5,6} @100, then vector load @100 -> rsp at t+7 with lanes 1..6; RAM[106] still 0; req_ready=0 during SEQ.
// - IO: sw_in=9'b1_0000_0101; wait 3 cycles; vector load @30000 -> lanes {1,0,1,0,0,0}; store @30000 leaves the read value unchanged.
// - Bounds: vector store @29997 with {7,8,9,10,11,12} -> RAM[29997..29999]=7,8,9; load @29997 -> {7,8,9,sw0,sw1,sw2}; load @40000 -> 0.
// - Dump: preload RAM[0..3]=0xA,0xB,0xC,0xD; pulse dump_start during a vector op, with dump_ready toggling every cycle -> dump begins after RESP; addr 0..3 give A..D, each held stable while not ready; dump_done once after addr 29999.
// - Reset: assert rst in the 3rd SEQ cycle of a vector store @200 -> RAM[200..202] written, RAM[203..205] unchanged; no rsp_valid; req_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/vdmem_seq_ram.sv
// vdmem_seq_ram
//   Data memory for the vector pipeline. Scalar and LANES-wide vector
//   loads/stores are sequenced one lane per cycle over a single-port
//   word RAM. Each accepted request produces exactly one rsp_valid pulse.
//   Part of the address space above the RAM maps synchronised switch
//   inputs. A rising edge on dump_start streams the whole RAM out through
//   a valid/ready dump port.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_we, req_vec           store/load select, vector/scalar select
//   req_addr, req_wdata       base word address, lane i at [i*W +: W]
//   rsp_valid, rsp_rdata      one-cycle response pulse and load data
//   sw_in                     asynchronous switch inputs
//   dump_start                asynchronous dump request (rising edge)
//   dump_valid / dump_ready   dump stream handshake
//   dump_addr, dump_data      address and RAM word of the current dump beat
//   dump_done                 one-cycle pulse after the last dump beat
module vdmem_seq_ram #(
  parameter int W           = 32,
  parameter int LANES       = 6,
  parameter int DEPTH       = 30000,
  parameter int AW          = 32,
  parameter int IO_BASE     = 30000,
  parameter int IO_BITS     = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_vec,
  input  logic [AW-1:0]        req_addr,
  input  logic [LANES*W-1:0]   req_wdata,
  output logic                 rsp_valid,
  output logic [LANES*W-1:0]   rsp_rdata,
  input  logic [IO_BITS-1:0]   sw_in,
  input  logic                 dump_start,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [AW-1:0]        dump_addr,
  output logic [W-1:0]         dump_data,
  output logic                 dump_done
);

  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = $clog2(DEPTH + 1);
  localparam int IW  = (IO_BITS > 1) ? $clog2(IO_BITS) : 1;

  // Lane addresses are compared one bit wider than AW so base+lane never wraps.
  localparam logic [AW:0]    RAM_END   = (AW+1)'(DEPTH);
  localparam logic [AW:0]    IO_LO     = (AW+1)'(IO_BASE);
  localparam logic [AW:0]    IO_HI     = (AW+1)'(IO_BASE + IO_BITS);
  localparam logic [PW-1:0]  DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);
  localparam logic [LW-1:0]  LANE_ONE  = LW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEQ = 2'd1, RESP = 2'd2, DUMP = 2'd3} state_t;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_RAM = 2'd1, SRC_IO = 2'd2} src_t;

  state_t state_r, state_s;
  logic   accept_s, enter_dump_s;

  // Latched request
  logic [AW-1:0]      base_r;
  logic               we_r, vec_r;
  logic [LANES*W-1:0] wdata_r;
  logic [LW-1:0]      lane_r;
  logic               last_lane_s;

  // Load-lane capture (RAM read data arrives one cycle after the lane issues)
  logic               cap_en_r;
  logic [LW-1:0]      cap_lane_r;
  src_t               cap_sel_r;
  logic               io_val_r;
  logic [W-1:0]       cap_word_s;
  logic [LANES*W-1:0] buf_r, buf_s;

  // Lane address decode
  logic [AW:0]        lane_sum_s;
  logic               in_ram_s, in_io_s;
  logic [IW-1:0]      io_idx_s;
  logic               io_bit_s;

  // RAM port
  logic [W-1:0]       mem [0:DEPTH-1];
  logic [W-1:0]       ram_q_r;
  logic [RAW-1:0]     ram_addr_s;
  logic               ram_we_s, ram_re_s;
  logic [W-1:0]       ram_wdata_s;

  // Synchronisers and dump request
  logic [IO_BITS-1:0]     sw_sync_r [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ds_sync_r;
  logic [IO_BITS-1:0]     sw_s;
  logic                   ds_s, ds_prev_r, ds_edge_s;
  logic                   pending_r, pending_s;

  // Dump streaming: one word in the RAM output register, one in the output slot
  logic [PW-1:0]      rd_ptr_r;
  logic               q_valid_r;
  logic [AW-1:0]      q_addr_r;
  logic               out_free_s, dump_issue_s, dump_last_hs_s;

  // Registered outputs
  logic               req_ready_r, rsp_valid_r, dump_valid_r, dump_done_r;
  logic [LANES*W-1:0] rsp_rdata_r;
  logic [AW-1:0]      dump_addr_r;
  logic [W-1:0]       dump_data_r;

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign dump_valid = dump_valid_r;
  assign dump_addr  = dump_addr_r;
  assign dump_data  = dump_data_r;
  assign dump_done  = dump_done_r;

  assign sw_s        = sw_sync_r[SYNC_STAGES-1];
  assign ds_s        = ds_sync_r[SYNC_STAGES-1];
  assign ds_edge_s   = ds_s && !ds_prev_r;
  assign pending_s   = ds_edge_s || (pending_r && !enter_dump_s);

  assign lane_sum_s  = {1'b0, base_r} + {{(AW+1-LW){1'b0}}, lane_r};
  assign in_ram_s    = (lane_sum_s < RAM_END);
  assign in_io_s     = (lane_sum_s >= IO_LO) && (lane_sum_s < IO_HI);
  assign io_idx_s    = IW'(lane_sum_s - IO_LO);
  assign io_bit_s    = sw_s[io_idx_s];
  assign last_lane_s = vec_r ? (lane_r == LAST_LANE) : 1'b1;

  assign out_free_s     = !dump_valid_r || dump_ready;
  assign dump_issue_s   = (state_r == DUMP) && (rd_ptr_r < DEPTH_P) && (!q_valid_r || out_free_s);
  assign dump_last_hs_s = (state_r == DUMP) && dump_valid_r && dump_ready && (dump_addr_r == LAST_ADDR);

  // Switch and dump_start synchronisers plus the single pending-dump flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_r[i] <= {IO_BITS{1'b0}};
      ds_sync_r <= {SYNC_STAGES{1'b0}};
      ds_prev_r <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      sw_sync_r[0] <= sw_in;
      ds_sync_r[0] <= dump_start;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_r[i] <= sw_sync_r[i-1];
        ds_sync_r[i] <= ds_sync_r[i-1];
      end
      ds_prev_r <= ds_s;
      pending_r <= pending_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // FSM next state; a pending dump wins over a new request in IDLE
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    enter_dump_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_r) begin
          state_s      = DUMP;
          enter_dump_s = 1'b1;
        end else if (req_valid && req_ready_r) begin
          state_s  = SEQ;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SEQ: begin
        if (last_lane_s) state_s = RESP;
        else             state_s = SEQ;
      end
      RESP:    state_s = IDLE;
      DUMP: begin
        if (dump_last_hs_s) state_s = IDLE;
        else                state_s = DUMP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Word returned for the lane issued in the previous cycle, merged into the lane buffer
  always_comb begin
    buf_s = buf_r;
    case (cap_sel_r)
      SRC_RAM: cap_word_s = ram_q_r;
      SRC_IO:  cap_word_s = {{(W-1){1'b0}}, io_val_r};
      default: cap_word_s = {W{1'b0}};
    endcase
    if (cap_en_r) buf_s[cap_lane_r*W +: W] = cap_word_s;
    else          buf_s = buf_r;
  end

  // Single RAM port shared by lane sequencing and the dump reader
  always_comb begin
    ram_addr_s  = {RAW{1'b0}};
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_wdata_s = {W{1'b0}};
    if (state_r == SEQ) begin
      ram_addr_s  = lane_sum_s[RAW-1:0];
      ram_we_s    = we_r && in_ram_s;
      ram_re_s    = !we_r && in_ram_s;
      ram_wdata_s = wdata_r[lane_r*W +: W];
    end else if (state_r == DUMP) begin
      ram_addr_s = RAW'(rd_ptr_r);
      ram_re_s   = dump_issue_s;
    end else begin
      ram_re_s = 1'b0;
    end
  end

  // Word RAM; no reset so contents survive rst, and q holds when not read
  always_ff @(posedge clk) begin
    if (ram_we_s) mem[ram_addr_s] <= ram_wdata_s;
    if (ram_re_s) ram_q_r <= mem[ram_addr_s];
  end

  // Request latch, lane sequencing, load capture and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r      <= {AW{1'b0}};
      we_r        <= 1'b0;
      vec_r       <= 1'b0;
      wdata_r     <= {(LANES*W){1'b0}};
      lane_r      <= {LW{1'b0}};
      buf_r       <= {(LANES*W){1'b0}};
      cap_en_r    <= 1'b0;
      cap_lane_r  <= {LW{1'b0}};
      cap_sel_r   <= SRC_NONE;
      io_val_r    <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {(LANES*W){1'b0}};
    end else begin
      req_ready_r <= (state_s == IDLE) && !pending_s;
      rsp_valid_r <= (state_r == RESP);
      cap_en_r    <= (state_r == SEQ) && !we_r;
      cap_lane_r  <= lane_r;
      cap_sel_r   <= in_ram_s ? SRC_RAM : (in_io_s ? SRC_IO : SRC_NONE);
      io_val_r    <= io_bit_s;
      if (accept_s) begin
        base_r  <= req_addr;
        we_r    <= req_we;
        vec_r   <= req_vec;
        wdata_r <= req_wdata;
        lane_r  <= {LW{1'b0}};
        buf_r   <= {(LANES*W){1'b0}};
      end else if (state_r == SEQ) begin
        lane_r <= lane_r + LANE_ONE;
        buf_r  <= buf_s;
      end else begin
        buf_r <= buf_s;
      end
      // The last load lane is captured on the RESP edge, so take the merged buffer.
      if (state_r == RESP) rsp_rdata_r <= buf_s;
      else                 rsp_rdata_r <= rsp_rdata_r;
    end
  end

  // Dump reader and output slot; the slot only reloads when empty or accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r     <= {PW{1'b0}};
      q_valid_r    <= 1'b0;
      q_addr_r     <= {AW{1'b0}};
      dump_valid_r <= 1'b0;
      dump_addr_r  <= {AW{1'b0}};
      dump_data_r  <= {W{1'b0}};
      dump_done_r  <= 1'b0;
    end else begin
      dump_done_r <= dump_last_hs_s;
      if (enter_dump_s) begin
        rd_ptr_r     <= {PW{1'b0}};
        q_valid_r    <= 1'b0;
        dump_valid_r <= 1'b0;
      end else if (state_r == DUMP) begin
        if (out_free_s) begin
          dump_valid_r <= q_valid_r;
          if (q_valid_r) begin
            dump_addr_r <= q_addr_r;
            dump_data_r <= ram_q_r;
          end
        end
        if (dump_issue_s) begin
          q_valid_r <= 1'b1;
          q_addr_r  <= AW'(rd_ptr_r);
          rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        end else if (q_valid_r && out_free_s) begin
          q_valid_r <= 1'b0;
        end
      end else begin
        dump_valid_r <= 1'b0;
        q_valid_r    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vdmem_seq_ram.sv
module tb_vdmem_seq_ram;
  localparam int W       = 32;
  localparam int LANES   = 6;
  localparam int DEPTH   = 30000;
  localparam int IO_BASE = 30000;
  localparam int IO_BITS = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic         req_vec = 1'b0;
  logic [31:0]  req_addr = 32'd0;
  logic [191:0] req_wdata = 192'd0;
  logic         rsp_valid;
  logic [191:0] rsp_rdata;
  logic [8:0]   sw_in = 9'd0;
  logic         dump_start = 1'b0;
  logic         dump_valid;
  logic         dump_ready = 1'b0;
  logic [31:0]  dump_addr;
  logic [31:0]  dump_data;
  logic         dump_done;

  int errors = 0;
  int checks = 0;

  // Reference model: plain word array plus the switch value currently applied
  logic [31:0] m_mem   [0:DEPTH-1];
  bit          m_known [0:DEPTH-1];
  logic [8:0]  cur_sw = 9'd0;

  vdmem_seq_ram dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_vec(req_vec),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sw_in(sw_in), .dump_start(dump_start),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one request; returns the expected response data
  task automatic model_access(input logic we, input logic vec, input logic [31:0] addr,
                              input logic [191:0] wd, output logic [191:0] exp);
    int n;
    longint a;
    n = vec ? LANES : 1;
    exp = 192'd0;
    for (int i = 0; i < n; i++) begin
      a = longint'({32'd0, addr}) + longint'(i);
      if (we) begin
        if (a < DEPTH) begin
          m_mem[a]   = wd[i*W +: W];
          m_known[a] = 1'b1;
        end
      end else begin
        if (a < DEPTH)
          exp[i*W +: W] = m_mem[a];
        else if (a >= IO_BASE && a < IO_BASE + IO_BITS)
          exp[i*W +: W] = {31'd0, cur_sw[a - IO_BASE]};
      end
    end
  endtask

  task automatic hs_only(input string tag, input logic we, input logic vec, input logic [31:0] addr,
                         input logic [191:0] wd, output logic ok);
    int k;
    req_we = we; req_vec = vec; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_accept"}, {191'd0, req_ready}, 192'd1);
    ok = req_ready;
    if (ok) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic vec, input logic [31:0] addr,
                     input logic [191:0] wd, input logic pulse, output logic [191:0] rd);
    logic [191:0] exp;
    logic ok, got, seen_rdy;
    int n, k;
    model_access(we, vec, addr, wd, exp);
    hs_only(tag, we, vec, addr, wd, ok);
    rd = 192'd0;
    if (ok) begin
      if (pulse) dump_start = 1'b1;
      n = vec ? LANES : 1;
      got = 1'b0; seen_rdy = 1'b0; k = 0;
      while (!got && k < 20) begin
        @(posedge clk); #1;
        k++;
        if (k == 3) dump_start = 1'b0;
        if (rsp_valid) got = 1'b1;
        else if (req_ready) seen_rdy = 1'b1;
      end
      dump_start = 1'b0;
      chk({tag, "_latency"}, 192'(k), 192'(n + 1));
      chk({tag, "_ready_low"}, {191'd0, seen_rdy}, 192'd0);
      chk({tag, "_rdata"}, rsp_rdata, exp);
      rd = rsp_rdata;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {191'd0, rsp_valid}, 192'd0);
    end
  endtask

  task automatic set_sw(input logic [8:0] v);
    sw_in = v;
    cur_sw = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] rand_vec();
    logic [191:0] v;
    for (int i = 0; i < LANES; i++) v[i*W +: W] = $urandom();
    return v;
  endfunction

  initial begin
    logic [191:0] rd;
    logic [31:0]  ra;
    logic ok, stall, seen_rsp;
    logic [31:0] prev_a, prev_d;
    int exp_a, cyc, early_done;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {191'd0, req_ready}, 192'd0);
    chk("rst_rsp_valid", {191'd0, rsp_valid}, 192'd0);
    chk("rst_rsp_rdata", rsp_rdata, 192'd0);
    chk("rst_dump", {127'd0, dump_valid, dump_addr, dump_data, dump_done}, 192'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_after", {191'd0, req_ready}, 192'd1);

    // Give every RAM word the bench later reads a defined value
    for (int b = 0; b < 72; b += 6) txn("prefill_lo", 1'b1, 1'b1, 32'(b), 192'd0, 1'b0, rd);
    for (int b = 29976; b < 30000; b += 6) txn("prefill_hi", 1'b1, 1'b1, 32'(b), 192'd0, 1'b0, rd);
    txn("prefill_100", 1'b1, 1'b1, 32'd100, 192'd0, 1'b0, rd);
    txn("prefill_106", 1'b1, 1'b1, 32'd106, 192'd0, 1'b0, rd);
    txn("prefill_200", 1'b1, 1'b1, 32'd200, rand_vec(), 1'b0, rd);

    // Scalar store/load
    txn("st_scalar", 1'b1, 1'b0, 32'd5, {160'd0, 32'hDEADBEEF}, 1'b0, rd);
    txn("ld_scalar", 1'b0, 1'b0, 32'd5, 192'd0, 1'b0, rd);
    chk("ld_scalar_const", rd, {160'd0, 32'hDEADBEEF});

    // Vector store/load
    txn("st_vec", 1'b1, 1'b1, 32'd100, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, rd);
    txn("ld_vec", 1'b0, 1'b1, 32'd100, 192'd0, 1'b0, rd);
    chk("ld_vec_const", rd, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    txn("ld_106", 1'b0, 1'b0, 32'd106, 192'd0, 1'b0, rd);
    chk("ld_106_const", rd, 192'd0);

    // Switch region
    set_sw(9'b1_0000_0101);
    txn("ld_io", 1'b0, 1'b1, 32'd30000, 192'd0, 1'b0, rd);
    chk("ld_io_const", rd, {32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1});
    txn("st_io", 1'b1, 1'b1, 32'd30000, rand_vec(), 1'b0, rd);
    txn("ld_io2", 1'b0, 1'b1, 32'd30000, 192'd0, 1'b0, rd);
    chk("ld_io2_const", rd, {32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1});

    // RAM/IO boundary and unmapped space
    txn("st_bound", 1'b1, 1'b1, 32'd29997, {32'd12, 32'd11, 32'd10, 32'd9, 32'd8, 32'd7}, 1'b0, rd);
    txn("ld_bound", 1'b0, 1'b1, 32'd29997, 192'd0, 1'b0, rd);
    chk("ld_bound_const", rd, {32'd1, 32'd0, 32'd1, 32'd9, 32'd8, 32'd7});
    txn("ld_40000", 1'b0, 1'b1, 32'd40000, 192'd0, 1'b0, rd);
    chk("ld_40000_const", rd, 192'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) set_sw(9'($urandom()));
      case ($urandom_range(0, 3))
        0:       ra = 32'($urandom_range(0, 63));
        1:       ra = 32'($urandom_range(29985, 30012));
        2:       ra = $urandom() | 32'h0001_0000;
        default: ra = 32'($urandom_range(30000, 30008));
      endcase
      txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rand_vec(), 1'b0, rd);
    end

    // Dump requested during a vector op, consumer toggling ready at first
    txn("dump_preload", 1'b1, 1'b1, 32'd0, {32'd0, 32'd0, 32'hD, 32'hC, 32'hB, 32'hA}, 1'b0, rd);
    txn("dump_trig", 1'b0, 1'b1, 32'd50, 192'd0, 1'b1, rd);
    chk("dump_after_resp", {191'd0, dump_valid}, 192'd0);
    exp_a = 0; cyc = 0; early_done = 0; stall = 1'b0; prev_a = 32'd0; prev_d = 32'd0;
    while (exp_a < DEPTH && cyc < 80000) begin
      @(posedge clk); #1;
      cyc++;
      if (dump_done) early_done++;
      if (stall) chk("dump_stable", {127'd0, dump_valid, dump_addr, dump_data}, {127'd0, 1'b1, prev_a, prev_d});
      dump_ready = (exp_a < 64) ? ~dump_ready : 1'b1;
      if (dump_valid) begin
        chk("dump_addr", {160'd0, dump_addr}, 192'(exp_a));
        if (m_known[exp_a]) chk("dump_data", {160'd0, dump_data}, {160'd0, m_mem[exp_a]});
        prev_a = dump_addr;
        prev_d = dump_data;
        stall  = ~dump_ready;
        if (dump_ready) exp_a++;
      end else begin
        stall = 1'b0;
      end
    end
    chk("dump_count", 192'(exp_a), 192'(DEPTH));
    chk("dump_no_early_done", 192'(early_done), 192'd0);
    @(posedge clk); #1;
    dump_ready = 1'b0;
    chk("dump_done_pulse", {190'd0, dump_done, dump_valid}, 192'd2);
    @(posedge clk); #1;
    chk("dump_done_clear", {191'd0, dump_done}, 192'd0);

    // Reset in the third SEQ cycle of a vector store
    rd = rand_vec();
    hs_only("rst_st", 1'b1, 1'b1, 32'd200, rd, ok);
    for (int i = 0; i < 3; i++) begin
      m_mem[200 + i] = rd[i*W +: W];
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midseq_rst_state", {190'd0, req_ready, rsp_valid}, 192'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midseq_ready_after", {191'd0, req_ready}, 192'd1);
    seen_rsp = rsp_valid;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("midseq_no_rsp", {191'd0, seen_rsp}, 192'd0);
    txn("midseq_ld", 1'b0, 1'b1, 32'd200, 192'd0, 1'b0, rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
